// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: segment bit positions,
// the blank pattern and the active-low hex glyph table.
package seg7_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Active-low glyphs for segments g..a, indexed by nibble value.
    localparam logic [6:0] HEX_SEG [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/seg7_hex_decode.sv
// Nibble plus decimal-point flag to active-low segment byte; purely combinational.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    output logic [7:0] seg
);

    always_comb begin
        seg         = SEG_BLANK;
        seg[SEG_G:SEG_A] = HEX_SEG[nibble];
        seg[SEG_DP] = ~dp;
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Scans four common-anode digits from a frame-synchronous snapshot of the PIO word,
// with PWM brightness and per-digit blanking; outputs are registered (1 cycle).
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int SLOT_CYCLES = 12500,
    parameter int NUM_DIGITS  = 4
)(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] data_in,
    input  logic        mode_raw,
    input  logic [3:0]  brightness,
    input  logic [3:0]  blank_mask,
    output logic [7:0]  seg_n,
    output logic [3:0]  dig_n,
    output logic        frame_tick
);

    localparam int CNT_W     = $clog2(SLOT_CYCLES);
    localparam int PHASE_LEN = SLOT_CYCLES / 16;
    localparam int PH_W      = (PHASE_LEN > 1) ? $clog2(PHASE_LEN) : 1;
    localparam logic [1:0] LAST_DIG = 2'(NUM_DIGITS - 1);

    logic [CNT_W-1:0] slot_cnt;
    logic [PH_W-1:0]  ph_cnt;
    logic [3:0]       phase;
    logic [1:0]       dig_idx;

    logic [31:0] sh_data;
    logic        sh_raw;
    logic [3:0]  sh_bright;
    logic [3:0]  sh_blank;

    logic       slot_wrap;
    logic       ph_wrap;
    logic       frame_end;
    logic       on;
    logic       guard;
    logic [7:0] hex_seg;
    logic [7:0] raw_seg;
    logic [7:0] seg_next;
    logic [3:0] dig_next;

    assign slot_wrap = (slot_cnt == CNT_W'(SLOT_CYCLES - 1));
    assign ph_wrap   = (ph_cnt == PH_W'(PHASE_LEN - 1));
    assign frame_end = slot_wrap && (dig_idx == LAST_DIG);

    // phase holds at 15 if SLOT_CYCLES is not an exact multiple of 16.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_cnt <= '0;
            ph_cnt   <= '0;
            phase    <= '0;
            dig_idx  <= '0;
        end else if (slot_wrap) begin
            slot_cnt <= '0;
            ph_cnt   <= '0;
            phase    <= '0;
            dig_idx  <= dig_idx + 2'd1;
        end else begin
            slot_cnt <= slot_cnt + CNT_W'(1);
            if (ph_wrap) begin
                ph_cnt <= '0;
                if (phase != 4'hF) begin
                    phase <= phase + 4'd1;
                end
            end else begin
                ph_cnt <= ph_cnt + PH_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sh_data   <= '0;
            sh_raw    <= 1'b0;
            sh_bright <= '0;
            sh_blank  <= '0;
        end else if (frame_end) begin
            sh_data   <= data_in;
            sh_raw    <= mode_raw;
            sh_bright <= brightness;
            sh_blank  <= blank_mask;
        end
    end

    seg7_hex_decode u_hex_decode (
        .nibble (sh_data[{dig_idx, 2'b00} +: 4]),
        .dp     (sh_data[{3'b100, dig_idx}]),
        .seg    (hex_seg)
    );

    assign raw_seg = sh_data[{dig_idx, 3'b000} +: 8];

    // The first two cycles of each slot keep all anodes off so the previous
    // digit's cathode pattern cannot ghost onto the next digit.
    always_comb begin
        on       = (phase < sh_bright) && !sh_blank[dig_idx];
        guard    = (slot_cnt < CNT_W'(2));
        seg_next = SEG_BLANK;
        dig_next = 4'hF;
        if (on) begin
            seg_next = sh_raw ? raw_seg : hex_seg;
            if (!guard) begin
                dig_next = ~(4'b0001 << dig_idx);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seg_n      <= SEG_BLANK;
            dig_n      <= 4'hF;
            frame_tick <= 1'b0;
        end else begin
            seg_n      <= seg_next;
            dig_n      <= dig_next;
            frame_tick <= frame_end;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver with a cycle-level reference model.
module tb_seg7_scan_driver;

    localparam int S     = 32;
    localparam int FRAME = 4 * S;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] data_in = 32'h0;
    logic        mode_raw = 1'b0;
    logic [3:0]  brightness = 4'h0;
    logic [3:0]  blank_mask = 4'h0;
    logic [7:0]  seg_n;
    logic [3:0]  dig_n;
    logic        frame_tick;

    always #5 clk = ~clk;

    seg7_scan_driver #(.SLOT_CYCLES(S), .NUM_DIGITS(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .data_in    (data_in),
        .mode_raw   (mode_raw),
        .brightness (brightness),
        .blank_mask (blank_mask),
        .seg_n      (seg_n),
        .dig_n      (dig_n),
        .frame_tick (frame_tick)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    function automatic logic [7:0] digit_byte(input logic [31:0] d, input logic raw, input int i);
        if (raw) return d[8*i +: 8];
        return {~d[16+i], glyph(d[4*i +: 4])};
    endfunction

    int          m_cyc;
    int          m_slot, m_dig, m_ph;
    bit          m_on;
    logic [31:0] m_data;
    logic        m_raw;
    logic [3:0]  m_bright, m_blank;
    logic [3:0]  m_sel;
    logic [7:0]  exp_seg;
    logic [3:0]  exp_dig;
    logic        exp_tick;

    // Outputs seen after an edge describe the position the display was at before it.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_cyc = 0; m_data = '0; m_raw = 0; m_bright = '0; m_blank = '0;
            exp_seg = 8'hFF; exp_dig = 4'hF; exp_tick = 1'b0;
        end else begin
            m_slot = m_cyc % S;
            m_dig  = (m_cyc / S) % 4;
            m_ph   = m_slot / (S / 16);
            if (m_ph > 15) m_ph = 15;
            m_on   = (m_ph < int'(m_bright)) && !m_blank[m_dig];
            m_sel  = 4'hF;
            m_sel[m_dig] = 1'b0;
            exp_seg  = m_on ? digit_byte(m_data, m_raw, m_dig) : 8'hFF;
            exp_dig  = (m_on && m_slot >= 2) ? m_sel : 4'hF;
            exp_tick = (m_cyc % FRAME) == FRAME - 1;
            if (exp_tick) begin
                m_data = data_in; m_raw = mode_raw; m_bright = brightness; m_blank = blank_mask;
            end
            m_cyc++;
        end
    end

    always @(negedge clk) begin
        check("scan", {19'h0, seg_n, dig_n, frame_tick}, {19'h0, exp_seg, exp_dig, exp_tick});
    end

    // ---------------- directed helpers ----------------
    typedef struct {
        logic [31:0] data;
        logic        raw;
        logic [3:0]  bright;
        logic [3:0]  blank;
        int          dig;
        logic [7:0]  seg;
        logic [3:0]  dn;
    } vec_t;

    vec_t vecs [20];

    task automatic wait_tick();
        int n = 0;
        @(negedge clk);
        while (!frame_tick && n < 2 * FRAME + 8) begin
            @(negedge clk);
            n++;
        end
        check("tick_wait", {31'h0, frame_tick}, 32'h1);
    endtask

    task automatic set_in(input logic [31:0] d, input logic r, input logic [3:0] b, input logic [3:0] m);
        data_in = d; mode_raw = r; brightness = b; blank_mask = m;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, checks %0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        int n, lit, segs, ticks;

        vecs[0]  = '{32'h0000_4321, 1'b0, 4'hF, 4'h0, 0, 8'hF9, 4'hE};
        vecs[1]  = '{32'h0000_4321, 1'b0, 4'hF, 4'h0, 1, 8'hA4, 4'hD};
        vecs[2]  = '{32'h0000_4321, 1'b0, 4'hF, 4'h0, 2, 8'hB0, 4'hB};
        vecs[3]  = '{32'h0000_4321, 1'b0, 4'hF, 4'h0, 3, 8'h99, 4'h7};
        vecs[4]  = '{32'h0000_FFFF, 1'b0, 4'hF, 4'h0, 0, 8'h8E, 4'hE};
        vecs[5]  = '{32'h0000_FFFF, 1'b0, 4'hF, 4'h0, 1, 8'h8E, 4'hD};
        vecs[6]  = '{32'h0000_FFFF, 1'b0, 4'hF, 4'h0, 2, 8'h8E, 4'hB};
        vecs[7]  = '{32'h0000_FFFF, 1'b0, 4'hF, 4'h0, 3, 8'h8E, 4'h7};
        vecs[8]  = '{32'h00C0_F9A4, 1'b1, 4'hF, 4'h0, 0, 8'hA4, 4'hE};
        vecs[9]  = '{32'h00C0_F9A4, 1'b1, 4'hF, 4'h0, 1, 8'hF9, 4'hD};
        vecs[10] = '{32'h00C0_F9A4, 1'b1, 4'hF, 4'h0, 2, 8'hC0, 4'hB};
        vecs[11] = '{32'h00C0_F9A4, 1'b1, 4'hF, 4'h0, 3, 8'h00, 4'h7};
        vecs[12] = '{32'h0003_1234, 1'b0, 4'hF, 4'h5, 0, 8'hFF, 4'hF};
        vecs[13] = '{32'h0003_1234, 1'b0, 4'hF, 4'h5, 1, 8'h30, 4'hD};
        vecs[14] = '{32'h0003_1234, 1'b0, 4'hF, 4'h5, 2, 8'hFF, 4'hF};
        vecs[15] = '{32'h0003_1234, 1'b0, 4'hF, 4'h5, 3, 8'hF9, 4'h7};
        vecs[16] = '{32'h0000_4321, 1'b0, 4'h0, 4'h0, 2, 8'hFF, 4'hF};
        vecs[17] = '{32'h0000_4321, 1'b0, 4'h3, 4'h0, 0, 8'hF9, 4'hE};
        vecs[18] = '{32'h0000_4321, 1'b0, 4'h2, 4'h0, 0, 8'hFF, 4'hF};
        vecs[19] = '{32'hFFFF_0008, 1'b0, 4'hF, 4'h0, 0, 8'h00, 4'hE};

        // Reset state and dark first frame.
        set_in(32'h0000_4321, 1'b0, 4'hF, 4'h0);
        repeat (3) @(negedge clk);
        check("reset_outputs", {19'h0, seg_n, dig_n, frame_tick}, {19'h0, 8'hFF, 4'hF, 1'b0});
        #2 reset_n = 1'b1;
        n = 0; lit = 0;
        while (!frame_tick && n < 2 * FRAME) begin
            @(negedge clk);
            n++;
            if (dig_n != 4'hF || seg_n != 8'hFF) lit++;
        end
        check("first_tick_delay", n, FRAME);
        check("first_frame_dark", lit, 0);

        // Table-driven digit checks at slot position 4 of the target digit.
        foreach (vecs[i]) begin
            set_in(vecs[i].data, vecs[i].raw, vecs[i].bright, vecs[i].blank);
            wait_tick();
            repeat (vecs[i].dig * S + 5) @(negedge clk);
            check($sformatf("vec%0d_seg", i), {24'h0, seg_n}, {24'h0, vecs[i].seg});
            check($sformatf("vec%0d_dig", i), {28'h0, dig_n}, {28'h0, vecs[i].dn});
        end

        // Mid-frame data change stays invisible until the next boundary.
        set_in(32'h0000_4321, 1'b0, 4'hF, 4'h0);
        wait_tick();
        wait_tick();
        repeat (S + 10) @(negedge clk);
        data_in = 32'h0000_FFFF;
        repeat (2 * S - 5) @(negedge clk);
        check("midframe_old_seg", {24'h0, seg_n}, 32'h99);
        check("midframe_old_dig", {28'h0, dig_n}, 32'h7);
        ticks = 0;
        repeat (FRAME) begin
            @(negedge clk);
            if (frame_tick) ticks++;
        end
        check("midframe_tick_count", ticks, 1);
        check("midframe_new_seg", {24'h0, seg_n}, 32'h8E);

        // Brightness 8: phases 0..7 lit, two of those cycles guarded.
        set_in(32'h0000_4321, 1'b0, 4'h8, 4'h0);
        wait_tick();
        wait_tick();
        lit = 0; segs = 0;
        repeat (S) begin
            @(negedge clk);
            if (dig_n != 4'hF) lit++;
            if (seg_n != 8'hFF) segs++;
        end
        check("bright8_dig_on", lit, 14);
        check("bright8_seg_on", segs, 16);

        // Brightness 0: whole frame dark.
        set_in(32'h0000_4321, 1'b0, 4'h0, 4'h0);
        wait_tick();
        lit = 0;
        repeat (FRAME) begin
            @(negedge clk);
            if (dig_n != 4'hF) lit++;
        end
        check("bright0_dark", lit, 0);

        // Asynchronous reset mid-slot, then recovery.
        set_in(32'h0000_4321, 1'b0, 4'hF, 4'h0);
        wait_tick();
        wait_tick();
        repeat (S + 10) @(negedge clk);
        check("pre_reset_lit", {28'h0, dig_n}, 32'hD);
        #2 reset_n = 1'b0;
        #1;
        check("async_reset_seg", {24'h0, seg_n}, 32'hFF);
        check("async_reset_dig", {28'h0, dig_n}, 32'hF);
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b1;
        n = 0; lit = 0;
        while (!frame_tick && n < 2 * FRAME) begin
            @(negedge clk);
            n++;
            if (dig_n != 4'hF) lit++;
        end
        check("rerelease_tick_delay", n, FRAME);
        check("rerelease_dark", lit, 0);
        repeat (5) @(negedge clk);
        check("resume_seg", {24'h0, seg_n}, 32'hF9);
        check("resume_dig", {28'h0, dig_n}, 32'hE);

        // Random inputs against the reference model.
        repeat (3000) begin
            @(negedge clk);
            if ($urandom_range(0, 15) == 0) begin
                set_in($urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                       4'($urandom_range(0, 15)));
            end
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
